// File: rtl/glyph_loader.sv
// glyph_loader: parses a byte stream of glyph packets (0xA5, code, rows of
// 4 bytes each, MSB byte first) and writes each assembled 32-bit row into
// a glyph RAM at code*CHAR_HEIGHT + row. Stalled packets are aborted by
// an idle-cycle timeout.
module glyph_loader #(
  parameter int CHAR_HEIGHT = 32,
  parameter int GLYPHS      = 11,
  parameter int TIMEOUT     = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        ram_we,
  output logic [9:0]  ram_addr,
  output logic [31:0] ram_wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [3:0]  char_count
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CODE  = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_WRITE = 2'd3;

  localparam int          RW        = (CHAR_HEIGHT > 1) ? $clog2(CHAR_HEIGHT) : 1;
  localparam logic [RW-1:0] LAST_ROW = RW'(CHAR_HEIGHT - 1);
  localparam logic [7:0]  SYNC      = 8'hA5;
  localparam logic [7:0]  NUM_CODES = 8'(GLYPHS);
  localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT - 1);
  localparam logic [9:0]  H10       = 10'(CHAR_HEIGHT);

  logic [1:0]    r_state;
  logic [9:0]    r_base;
  logic [RW-1:0] r_row;
  logic [1:0]    r_bidx;
  logic [23:0]   r_word;     // first three bytes of the current row
  logic [15:0]   r_tmo;
  logic [9:0]    r_addr;
  logic [31:0]   r_wdata;
  logic          r_err;
  logic [3:0]    r_cnt;

  logic          w_take;
  logic          w_last;
  logic          w_tmo_hit;
  logic [9:0]    w_code_base;

  // WRITE is the only cycle that refuses a byte, giving the RAM port a free slot
  assign in_ready    = (r_state != S_WRITE);
  assign w_take      = in_valid & in_ready;
  assign w_last      = (r_row == LAST_ROW);
  assign w_tmo_hit   = (r_tmo == TMO_LAST);
  assign w_code_base = 10'(in_data) * H10;

  assign ram_we      = (r_state == S_WRITE);
  assign ram_addr    = r_addr;
  assign ram_wdata   = r_wdata;
  assign busy        = (r_state != S_IDLE);
  assign done        = ram_we & w_last;
  assign err         = r_err;
  assign char_count  = r_cnt;

  // Packet FSM, row assembly, timeout and glyph counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_base  <= '0;
      r_row   <= '0;
      r_bidx  <= '0;
      r_word  <= '0;
      r_tmo   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // non-sync bytes are silently dropped
          if (w_take && in_data == SYNC) begin
            r_state <= S_CODE;
            r_tmo   <= '0;
          end
        end
        S_CODE: begin
          if (w_take) begin
            r_tmo <= '0;
            if (in_data < NUM_CODES) begin
              r_base  <= w_code_base;
              r_row   <= '0;
              r_bidx  <= '0;
              r_state <= S_DATA;
            end else begin
              r_err   <= 1'b1;
              r_state <= S_IDLE;
            end
          end else if (w_tmo_hit) begin
            r_err   <= 1'b1;
            r_tmo   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_tmo <= r_tmo + 16'd1;
          end
        end
        S_DATA: begin
          if (w_take) begin
            r_tmo  <= '0;
            r_word <= {r_word[15:0], in_data};
            r_bidx <= r_bidx + 2'd1;
            if (r_bidx == 2'd3) begin
              // address/data registered here so they hold after the write
              r_addr  <= r_base + 10'(r_row);
              r_wdata <= {r_word, in_data};
              r_state <= S_WRITE;
            end
          end else if (w_tmo_hit) begin
            r_err   <= 1'b1;
            r_tmo   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_tmo <= r_tmo + 16'd1;
          end
        end
        default: begin // S_WRITE
          if (w_last) begin
            r_state <= S_IDLE;
            if (r_cnt != 4'd15) r_cnt <= r_cnt + 4'd1;
          end else begin
            r_row   <= r_row + RW'(1);
            r_bidx  <= '0;
            r_state <= S_DATA;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_glyph_loader.sv
// Testbench for glyph_loader: scoreboard of expected RAM writes, a negedge
// monitor logging observed writes/pulses, and one task per scenario.
module tb_glyph_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        ram_we;
  logic [9:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [3:0]  char_count;

  always #5 clk = ~clk;

  glyph_loader #(.CHAR_HEIGHT(32), .GLYPHS(11), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .busy(busy), .done(done), .err(err),
    .char_count(char_count)
  );

  typedef struct packed {
    logic [9:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];

  logic [9:0]  obs_addr [2048];
  logic [31:0] obs_data [2048];
  logic        obs_rdy  [2048];
  int obs_n  = 0;
  int done_n = 0;
  int err_n  = 0;
  int both_n = 0;

  int checks = 0;
  int errors = 0;
  int rd     = 0;

  // Monitor: log every RAM write and count pulses, sampled mid-cycle
  always @(negedge clk) begin
    if (ram_we && obs_n < 2048) begin
      obs_addr[obs_n] <= ram_addr;
      obs_data[obs_n] <= ram_wdata;
      obs_rdy[obs_n]  <= in_ready;
      obs_n           <= obs_n + 1;
    end
    if (done) done_n <= done_n + 1;
    if (err)  err_n  <= err_n + 1;
    if (done && err) both_n <= both_n + 1;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    bit ok;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 64) begin
      ok = in_ready;
      @(posedge clk);
      if (!ok) @(negedge clk);
      n++;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_byte: byte %h not accepted within 64 cycles", b);
    end
  endtask

  task automatic gap(input int maxgap);
    int g;
    if (maxgap > 0) begin
      g = $urandom_range(maxgap, 0);
      if (g > 0) idle(g);
    end
  endtask

  // Sends sync, code and the first nbytes of data; expected writes are
  // pushed for every row completed. mode 0: row r = {r,r,r,r}, else random.
  task automatic send_glyph(input logic [7:0] code, input int mode,
                            input int maxgap, input int nbytes);
    logic [31:0] word;
    logic [7:0]  rb;
    wr_t         e;
    gap(maxgap);
    send_byte(8'hA5);
    gap(maxgap);
    send_byte(code);
    for (int r = 0; r < 32; r++) begin
      rb   = 8'(r);
      word = (mode == 0) ? {rb, rb, rb, rb} : $urandom;
      for (int b = 0; b < 4; b++) begin
        if (r * 4 + b < nbytes) begin
          gap(maxgap);
          send_byte(word[31 - 8*b -: 8]);
        end
      end
      if (r * 4 + 4 <= nbytes) begin
        e.addr = 10'(code) * 10'd32 + 10'(r);
        e.data = word;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic sb_compare(input string name);
    wr_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (rd >= obs_n) begin
        errors++;
        $display("FAIL %s write missing: required addr %0d data %h", name, e.addr, e.data);
      end else begin
        if (obs_addr[rd] !== e.addr || obs_data[rd] !== e.data || obs_rdy[rd] !== 1'b0) begin
          errors++;
          $display("FAIL %s write %0d: got addr %0d data %h rdy %b, required addr %0d data %h rdy 0",
                   name, rd, obs_addr[rd], obs_data[rd], obs_rdy[rd], e.addr, e.data);
        end
        rd++;
      end
    end
    checks++;
    if (rd != obs_n) begin
      errors++;
      $display("FAIL %s extra writes: got %0d total, required %0d", name, obs_n, rd);
      rd = obs_n;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({in_ready, ram_we, ram_addr, ram_wdata, busy, done, err, char_count} !==
        {1'b1, 1'b0, 10'd0, 32'd0, 1'b0, 1'b0, 1'b0, 4'd0}) begin
      errors++;
      $display("FAIL reset_state: rdy %b we %b addr %0d wd %h busy %b done %b err %b cnt %0d, required 1 0 0 0 0 0 0 0",
               in_ready, ram_we, ram_addr, ram_wdata, busy, done, err, char_count);
    end
    rst = 1'b0;
  endtask

  task automatic test_digit3();
    int d0, e0;
    d0 = done_n; e0 = err_n;
    send_glyph(8'h03, 0, 0, 128);
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 10'd127 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL digit3_last_write: done %b we %b addr %0d rdy %b, required 1 1 127 0",
               done, ram_we, ram_addr, in_ready);
    end
    idle(3);
    sb_compare("digit3");
    checks++;
    if (done_n - d0 != 1) begin
      errors++; $display("FAIL digit3_done: got %0d pulses, required 1", done_n - d0);
    end
    checks++;
    if (err_n != e0 || char_count !== 4'd1 || busy !== 1'b0) begin
      errors++; $display("FAIL digit3_state: err %0d cnt %0d busy %b, required 0 1 0", err_n - e0, char_count, busy);
    end
  endtask

  task automatic test_drop();
    int e0;
    e0 = err_n;
    send_byte(8'h12);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL drop_12: busy %b, required 0", busy);
    end
    send_byte(8'h7F);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL drop_7f: busy %b, required 0", busy);
    end
    send_glyph(8'h0A, 1, 0, 128);
    idle(3);
    sb_compare("colon");
    checks++;
    if (err_n != e0 || char_count !== 4'd2) begin
      errors++; $display("FAIL colon_state: err %0d cnt %0d, required 0 2", err_n - e0, char_count);
    end
  endtask

  task automatic test_bad_code();
    int e0, n0;
    e0 = err_n; n0 = obs_n;
    send_byte(8'hA5);
    send_byte(8'h0B);
    @(negedge clk);
    checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL badcode_pulse: err %b busy %b, required 1 0", err, busy);
    end
    @(negedge clk);
    checks++;
    if (err !== 1'b0) begin
      errors++; $display("FAIL badcode_one_cycle: err %b, required 0", err);
    end
    idle(3);
    checks++;
    if (err_n - e0 != 1 || obs_n != n0 || char_count !== 4'd2) begin
      errors++; $display("FAIL badcode_state: errs %0d writes %0d cnt %0d, required 1 0 2",
                         err_n - e0, obs_n - n0, char_count);
    end
  endtask

  task automatic test_timeout();
    int e0;
    e0 = err_n;
    send_glyph(8'h00, 1, 0, 6);
    idle(15);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || err !== 1'b0) begin
      errors++; $display("FAIL timeout_early: busy %b err %b after 15 idle, required 1 0", busy, err);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL timeout_abort: err %b busy %b after 16 idle, required 1 0", err, busy);
    end
    idle(3);
    sb_compare("timeout");
    checks++;
    if (err_n - e0 != 1 || char_count !== 4'd2) begin
      errors++; $display("FAIL timeout_state: errs %0d cnt %0d, required 1 2", err_n - e0, char_count);
    end
  endtask

  task automatic test_reset_mid();
    int e0, n0;
    send_glyph(8'h05, 0, 0, 50);
    idle(2);
    sb_compare("partial");
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = 8'h33;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    e0 = err_n; n0 = obs_n;
    checks++;
    if ({in_ready, ram_we, ram_addr, ram_wdata, busy, done, err, char_count} !==
        {1'b1, 1'b0, 10'd0, 32'd0, 1'b0, 1'b0, 1'b0, 4'd0}) begin
      errors++;
      $display("FAIL midreset_state: rdy %b we %b addr %0d wd %h busy %b done %b err %b cnt %0d, required 1 0 0 0 0 0 0 0",
               in_ready, ram_we, ram_addr, ram_wdata, busy, done, err, char_count);
    end
    idle(4);
    checks++;
    if (err_n != e0 || obs_n != n0) begin
      errors++; $display("FAIL midreset_quiet: errs %0d writes %0d, required 0 0", err_n - e0, obs_n - n0);
    end
    send_glyph(8'h01, 1, 0, 128);
    idle(3);
    sb_compare("after_reset");
    checks++;
    if (char_count !== 4'd1) begin
      errors++; $display("FAIL after_reset_count: cnt %0d, required 1", char_count);
    end
  endtask

  task automatic test_saturate();
    int d0, e0;
    d0 = done_n; e0 = err_n;
    for (int i = 0; i < 16; i++) begin
      send_glyph(8'($urandom_range(10, 0)), 1, 3, 128);
      idle(3);
      sb_compare("saturate");
    end
    checks++;
    if (char_count !== 4'd15 || done_n - d0 != 16 || err_n != e0) begin
      errors++; $display("FAIL saturate_state: cnt %0d dones %0d errs %0d, required 15 16 0",
                         char_count, done_n - d0, err_n - e0);
    end
    checks++;
    if (both_n != 0) begin
      errors++; $display("FAIL done_err_overlap: got %0d cycles, required 0", both_n);
    end
  endtask

  initial begin
    test_reset();
    test_digit3();
    test_drop();
    test_bad_code();
    test_timeout();
    test_reset_mid();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/glyph_loader.md
GLYPH_LOADER -- requirements
Module: glyph_loader

Interface
REQ-001 Parameter CHAR_HEIGHT, default 32, rows per glyph (one 32-bit word per row).
REQ-002 Parameter GLYPHS, default 11, number of valid glyph codes (0-9 digits, 10 colon).
REQ-003 Parameter TIMEOUT, default 65535, idle cycles allowed inside a packet before abort (16-bit counter).
REQ-004 Port clk  input  1  system clock; one clock; all logic on rising edge.
REQ-005 Port rst  input  1  reset, synchronous, active-high.
REQ-006 Port in_valid  input  1  byte-stream valid.
REQ-007 Port in_data  input  8  byte-stream data.
REQ-008 Port in_ready  output  1  loader accepts in_data this cycle.
REQ-009 Port ram_we  output  1  glyph-RAM write strobe, one cycle per row.
REQ-010 Port ram_addr  output  10  glyph-RAM word address.
REQ-011 Port ram_wdata  output  32  glyph row; bit 31 = leftmost pixel.
REQ-012 Port busy  output  1  high while in any state other than IDLE.
REQ-013 Port done  output  1  one-cycle pulse, glyph fully written.
REQ-014 Port err  output  1  one-cycle pulse, packet aborted.
REQ-015 Port char_count  output  4  glyphs loaded since reset, saturating at 15.

Function
REQ-016 Byte transfer occurs when in_valid and in_ready are both high on a clock edge; no other byte is consumed.
REQ-017 Packet format: sync byte 0xA5, code byte, then CHAR_HEIGHT x 4 data bytes, each row MSB byte first (first byte -> ram_wdata[31:24]).
REQ-018 States: IDLE, CODE, DATA, WRITE.
REQ-019 IDLE: in_ready=1; 0xA5 -> CODE; any other byte dropped, stay IDLE, no err.
REQ-020 CODE: in_ready=1; code < GLYPHS -> latch base = code*CHAR_HEIGHT, row=0, byte index=0, -> DATA; code >= GLYPHS -> err pulse next cycle, -> IDLE.
REQ-021 DATA: in_ready=1; each byte shifts into row word; on 4th byte of a row -> WRITE.
REQ-022 WRITE: lasts exactly one cycle; in_ready=0; ram_we=1, ram_addr=base+row, ram_wdata=assembled word.
REQ-023 WRITE exit: row < CHAR_HEIGHT-1 -> row+1, byte index 0, DATA; row = CHAR_HEIGHT-1 -> done pulse in the same cycle, char_count+1 (hold at 15), -> IDLE.
REQ-024 Latency: ram_we asserts the cycle after the 4th byte of a row is accepted.
REQ-025 Address arithmetic in 10 bits; with defaults max address 351, no wrap.
REQ-026 Timeout: in CODE or DATA, counter clears on each accepted byte, increments otherwise; reaching TIMEOUT -> err pulse, -> IDLE, partial rows already written remain in RAM, char_count unchanged.
REQ-027 0xA5 received in CODE or DATA is treated as data/code, not resync.
REQ-028 done and err never assert in the same cycle; ram_we never asserts outside WRITE.
REQ-029 ram_addr and ram_wdata hold last written values when ram_we=0.

Reset
REQ-030 rst high at a clock edge: state IDLE, in_ready=1, ram_we=0, ram_addr=0, ram_wdata=0, busy=0, done=0, err=0, char_count=0, all counters 0.
REQ-031 rst asserted mid-packet aborts with no err pulse and no further ram_we; rst overrides all other inputs in that cycle.

Verification
REQ-032 Bench: stream 0xA5, 0x03, 128 bytes with row r = {r,r,r,r}, back-to-back valid -> 32 writes, addr 96..127, wdata 0x00000000..0x1F1F1F1F, in_ready low each WRITE cycle, done once, char_count=1.
REQ-033 Bench: 0x12, 0x7F, then 0xA5, 0x0A plus full glyph -> first two bytes dropped, writes at 320..351, no err.
REQ-034 Bench: 0xA5, 0x0B -> err pulse, no ram_we, busy returns 0, char_count unchanged.
REQ-035 Bench with TIMEOUT=16: 0xA5, 0x00, 6 bytes then valid low 16 cycles -> one write at addr 0, err pulse, IDLE.
REQ-036 Bench: rst high for one cycle after 50 data bytes -> outputs at reset values next cycle, subsequent clean packet loads correctly.
REQ-037 Bench: 16 clean packets with random valid gaps -> char_count saturates at 15, every word matches the reference model.
